fetch_sequencer: RTL and testbench
==================================

# fetch_sequencer

Instruction-fetch controller for the single-issue core. It owns the program counter and drives the word address of the combinational `InstMem` (64 × 32). It captures each fetched word with its PC into a small queue and hands instructions to decode over a valid/ready handshake. It also applies branch/jump redirects and halt requests from the execute stage.

## Interface
- `ADDR_W`, 8: PC/byte-address width; matches `InstMem` addr.
- `DEPTH`, 2: fetch-queue entries; must be 2 or more for full throughput.
- `RESET_PC`, 8'h00: PC loaded at reset; low 2 bits must be 0.

- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  synchronous reset, active low.
- `imem_addr`  out  ADDR_W  byte address to `InstMem`; always equals the current PC.
- `imem_instr`  in  32  combinational read data from `InstMem`.
- `redirect_valid`  in  1  one-cycle pulse: branch/jump taken.
- `redirect_pc`  in  ADDR_W  target byte address; bits [1:0] are ignored.
- `halt`  in  1  level: suspend fetching while high.
- `out_valid`  out  1  queue head is valid.
- `out_ready`  in  1  decode accepts the head this cycle.
- `out_instr`  out  32  head instruction; 32'h0 when empty.
- `out_pc`  out  ADDR_W  head PC; 0 when empty.
- `halted`  out  1  FSM is in HALTED.

## Operation
- **FSM states:** FETCH, HALTED. Reset enters FETCH.
  - FETCH → HALTED when `halt`=1.
  - HALTED → FETCH on the first cycle with `halt`=0.
- **Push:** happens in FETCH when the queue is not full, or is full and popping this cycle, and `redirect_valid`=0. A push stores {pc, `imem_instr`} and sets pc ← pc + 4.
- **PC arithmetic:** ADDR_W bits, modulo 2^ADDR_W. 8'hFC + 4 wraps to 8'h00.
- **Pop:** happens when `out_valid` && `out_ready`. Output is the FIFO head, in order.
- **Redirect (highest priority):**
  - Sets pc ← {`redirect_pc`[ADDR_W-1:2], 2'b00}.
  - Flushes every queue entry; no push in that cycle.
  - A pop in the same cycle still counts as a completed transfer before the flush.
  - Accepted in both states; does not change the FSM state.
- **HALTED:** no pushes and pc is held. The queue keeps draining to decode. `halted`=1.
- **Simultaneous events:**
  - `halt` and push-eligible in the same FETCH cycle: no push; HALTED next cycle.
  - `redirect_valid` and `halt` together: pc is redirected, the queue is flushed, and the FSM enters HALTED.
- **Reset mid-operation:** the queue is emptied and pc ← `RESET_PC` on the next edge. Any in-flight entry is discarded.

## Timing
- **Reset values:**
  - `out_valid`=0, `out_instr`=0, `out_pc`=0, `halted`=0.
  - `imem_addr`=`RESET_PC` (during reset and on the first cycle after it).
- `imem_addr` is a direct register output, with no combinational path from any input.
- **Fetch latency:** the word at pc is pushed at edge N and `out_valid` is 1 from cycle N+1.
- **After reset:** the first cycle with `rst_n`=1 pushes `RESET_PC`, so `out_valid`=1 on the second cycle.
- **Throughput:** 1 instruction/cycle with `out_ready` held 1. Back-pressure fills DEPTH entries, then the PC stalls.
- **After redirect at edge N:** `out_valid`=0 in cycle N+1, the target instruction appears in N+2, and no stale entry ever appears after the redirect.
- **Handshake:** `out_instr`/`out_pc` stay stable while `out_valid`=1 and `out_ready`=0.
- `halted` is registered: it rises 1 cycle after `halt` rises and falls 1 cycle after `halt` falls.

## Structure
- Package `fetch_pkg`:
  - state enum {FETCH, HALTED}
  - `PC_STEP`=4
  - default `RESET_PC`
  - queue entry struct {pc, instr}
- Sub-module `fetch_queue`: a DEPTH-entry synchronous FIFO with push, pop, flush, full, empty and head outputs.
  - Flush has priority over push; pop is evaluated before flush.
- `fetch_sequencer` holds the pc register, the FSM, and the push/redirect logic.

## Test plan
The bench uses `InstMem` with the program image word0=32'h00007033, word1=32'h00100093, word2=32'h00200113, word3=32'h00308193.

- **Reset then stream:** release reset with `out_ready`=1 → outputs (pc,instr) = (00,00007033), (04,00100093), (08,00200113), (0C,00308193) on consecutive cycles; first valid on the 2nd cycle after reset.
- **Back-pressure:** hold `out_ready`=0 for 5 cycles → queue holds 2 entries, `imem_addr` stalls at 8'h08 and the head is stable at (00,00007033); release → 04 and 08 follow with no gap and no duplicate.
- **Redirect:** pulse `redirect_valid` with `redirect_pc`=8'h0D while streaming → the next valid is (0C,00308193), 2 cycles later, and no queued older entry appears.
- **Halt:** assert `halt` for 4 cycles → `halted`=1 after 1 cycle, the queue drains, `out_valid`=0, and pc is held; deassert → fetching resumes at the held pc.
- **Wrap-around:** redirect to 8'hFC → next PCs are FC, 00, 04.
- **Reset mid-stream:** assert `rst_n`=0 for 1 cycle with 2 entries queued → `out_valid`=0, then restart at (00,00007033).

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the instruction-fetch sequencer
package fetch_pkg;

  // Sequencer FSM: either fetching words or parked by the execute stage.
  typedef enum logic [0:0] {
    ST_FETCH  = 1'b0,
    ST_HALTED = 1'b1
  } fetch_state_e;

  // One instruction word per fetch, so the PC advances by one 32-bit word.
  localparam int PC_STEP = 4;

  localparam int              DEFAULT_ADDR_W   = 8;
  localparam logic [7:0]      DEFAULT_RESET_PC = 8'h00;

  // Queue entry layout at the default address width: PC above the instruction.
  typedef struct packed {
    logic [DEFAULT_ADDR_W-1:0] pc;
    logic [31:0]               instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - small synchronous FIFO holding fetched {pc, instr} entries
module fetch_queue #(
  parameter int DEPTH  = 2,
  parameter int DATA_W = 40
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic              o_full,
  output logic              o_empty,
  output logic [DATA_W-1:0] o_head
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [CNT_W-1:0]  r_count;

  logic w_do_pop;
  logic w_do_push;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? '0 : ptr + PTR_W'(1);
  endfunction

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  // Empty queue presents zeros so decode never sees stale data.
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

  // Pointer/occupancy update; flush (and reset) wins over any push in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= ptr_next(r_wr_ptr);
      if (w_do_pop)  r_rd_ptr <= ptr_next(r_rd_ptr);
      if (w_do_push && !w_do_pop)      r_count <= r_count + CNT_W'(1);
      else if (!w_do_push && w_do_pop) r_count <= r_count - CNT_W'(1);
    end
  end

  // Entry storage; contents are only meaningful below the occupancy count.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush && rst_n) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/fetch_sequencer.sv
// rtl/fetch_sequencer.sv - program counter, halt FSM and redirect handling for instruction fetch
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = 8,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_instr,
  output logic [ADDR_W-1:0] out_pc,
  output logic              halted
);

  localparam int ENTRY_W = ADDR_W + 32;

  fetch_state_e        r_state;
  logic [ADDR_W-1:0]   r_pc;

  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic                w_push;
  logic [ENTRY_W-1:0]  w_head;
  logic [ADDR_W-1:0]   w_redirect_target;
  logic [ADDR_W-1:0]   w_pc_inc;

  // Targets are word aligned; the low two byte-offset bits are simply cleared.
  assign w_redirect_target = redirect_pc & ~ADDR_W'(2'b11);
  assign w_pc_inc          = r_pc + ADDR_W'(PC_STEP);

  assign w_pop  = out_valid & out_ready;
  // A redirect or a halt request suppresses the fetch of the current word.
  assign w_push = (r_state == ST_FETCH) & ~halt & ~redirect_valid & (~w_full | w_pop);

  assign imem_addr = r_pc;
  assign out_valid = ~w_empty;
  assign out_pc    = w_head[ENTRY_W-1:32];
  assign out_instr = w_head[31:0];
  assign halted    = (r_state == ST_HALTED);

  // Halt is a level: the FSM simply follows it one cycle later, redirect or not.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_FETCH;
    end else if (halt) begin
      r_state <= ST_HALTED;
    end else begin
      r_state <= ST_FETCH;
    end
  end

  // PC: redirect has priority, otherwise advance only when a word was captured.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_pc <= w_redirect_target;
    end else if (w_push) begin
      r_pc <= w_pc_inc;
    end
  end

  fetch_queue #(
    .DEPTH  (DEPTH),
    .DATA_W (ENTRY_W)
  ) u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  ({r_pc, imem_instr}),
    .i_pop   (w_pop),
    .i_flush (redirect_valid),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_head  (w_head)
  );

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb/tb_fetch_sequencer.sv - scoreboard testbench for fetch_sequencer
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [7:0]  redirect_pc;
  logic        halt;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [7:0]  out_pc;
  logic        halted;

  logic [31:0] imem [64];
  logic [39:0] exp_q [$];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign imem_instr = imem[imem_addr[7:2]];

  fetch_sequencer #(
    .ADDR_W   (8),
    .DEPTH    (2),
    .RESET_PC (8'h00)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .halted         (halted)
  );

  initial begin
    for (int i = 0; i < 64; i++) imem[i] = 32'hC0DE0000 | 32'(i);
    imem[0] = 32'h00007033;
    imem[1] = 32'h00100093;
    imem[2] = 32'h00200113;
    imem[3] = 32'h00308193;
  end

  // Scoreboard: every completed transfer must match the next expected entry.
  always @(negedge clk) begin
    logic [39:0] e;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h, want no transfer", out_pc, out_instr);
      end else begin
        e = exp_q.pop_front();
        if ({out_pc, out_instr} !== e) begin
          bad++;
          $display("FAIL sb_data: got pc=%h instr=%h, want pc=%h instr=%h",
                   out_pc, out_instr, e[39:32], e[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset;
    rst_n = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    halt = 1'b0;
    tick();
    exp_q.delete();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    out_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 8'h00;
    halt = 1'b0;
    tick();
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    total++; if (out_instr !== 32'h0) begin bad++; $display("FAIL rst_instr: got %h want 0", out_instr); end
    total++; if (out_pc !== 8'h00) begin bad++; $display("FAIL rst_pc: got %h want 00", out_pc); end
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL rst_halted: got %b want 0", halted); end
    total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL rst_addr: got %h want 00", imem_addr); end
  endtask

  task automatic test_stream;
    exp_q.push_back({8'h00, 32'h00007033});
    exp_q.push_back({8'h04, 32'h00100093});
    exp_q.push_back({8'h08, 32'h00200113});
    exp_q.push_back({8'h0C, 32'h00308193});
    rst_n = 1'b1;
    out_ready = 1'b1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL stream_first_cycle_valid: got %b want 0", out_valid); end
    total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL stream_first_addr: got %h want 00", imem_addr); end
    tick();
    total++; if (out_pc !== 8'h00) begin bad++; $display("FAIL stream_first_pc: got %h want 00", out_pc); end
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid_%0d: got %b want 1", i, out_valid); end
    end
    tick();
    out_ready = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL stream_drained: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_back_pressure;
    apply_reset();
    exp_q.push_back({8'h00, 32'h00007033});
    exp_q.push_back({8'h04, 32'h00100093});
    exp_q.push_back({8'h08, 32'h00200113});
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (out_pc !== 8'h00 || out_instr !== 32'h00007033)
        begin bad++; $display("FAIL bp_head_stable_%0d: got %h/%h want 00/00007033", i, out_pc, out_instr); end
    end
    total++; if (imem_addr !== 8'h08) begin bad++; $display("FAIL bp_addr_stall: got %h want 08", imem_addr); end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || out_pc !== 8'h04) begin bad++; $display("FAIL bp_second: got %b/%h want 1/04", out_valid, out_pc); end
    tick();
    total++; if (out_valid !== 1'b1 || out_pc !== 8'h08) begin bad++; $display("FAIL bp_third: got %b/%h want 1/08", out_valid, out_pc); end
    tick();
    out_ready = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL bp_drained: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_redirect;
    apply_reset();
    exp_q.push_back({8'h00, 32'h00007033});
    exp_q.push_back({8'h04, 32'h00100093});
    exp_q.push_back({8'h0C, 32'h00308193});
    out_ready = 1'b1;
    tick();
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 8'h0D;
    tick();
    redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL redir_bubble: got %b want 0", out_valid); end
    total++; if (imem_addr !== 8'h0C) begin bad++; $display("FAIL redir_addr: got %h want 0C", imem_addr); end
    tick();
    total++; if (out_valid !== 1'b1 || out_pc !== 8'h0C || out_instr !== 32'h00308193)
      begin bad++; $display("FAIL redir_target: got %b/%h/%h want 1/0C/00308193", out_valid, out_pc, out_instr); end
    tick();
    out_ready = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL redir_drained: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_halt;
    apply_reset();
    exp_q.push_back({8'h00, 32'h00007033});
    exp_q.push_back({8'h04, 32'h00100093});
    exp_q.push_back({8'h08, 32'h00200113});
    tick();
    tick();
    halt = 1'b1;
    out_ready = 1'b1;
    total++; if (halted !== 1'b0) begin bad++; $display("FAIL halt_not_yet: got %b want 0", halted); end
    tick();
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_rise: got %b want 1", halted); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL halt_drained: got %b want 0", out_valid); end
    total++; if (imem_addr !== 8'h08) begin bad++; $display("FAIL halt_pc_held: got %h want 08", imem_addr); end
    tick();
    tick();
    halt = 1'b0;
    total++; if (halted !== 1'b1) begin bad++; $display("FAIL halt_still: got %b want 1", halted); end
    tick();
    total++; if (halted !== 1'b0 || out_valid !== 1'b0) begin bad++; $display("FAIL halt_fall: got %b/%b want 0/0", halted, out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || out_pc !== 8'h08) begin bad++; $display("FAIL halt_resume: got %b/%h want 1/08", out_valid, out_pc); end
    tick();
    out_ready = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL halt_left: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_wrap;
    apply_reset();
    exp_q.push_back({8'hFC, 32'hC0DE003F});
    exp_q.push_back({8'h00, 32'h00007033});
    exp_q.push_back({8'h04, 32'h00100093});
    redirect_valid = 1'b1;
    redirect_pc = 8'hFC;
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    total++; if (imem_addr !== 8'hFC) begin bad++; $display("FAIL wrap_target: got %h want FC", imem_addr); end
    tick();
    total++; if (out_pc !== 8'hFC || imem_addr !== 8'h00) begin bad++; $display("FAIL wrap_roll: got %h/%h want FC/00", out_pc, imem_addr); end
    tick();
    total++; if (out_pc !== 8'h00) begin bad++; $display("FAIL wrap_zero: got %h want 00", out_pc); end
    tick();
    total++; if (out_pc !== 8'h04) begin bad++; $display("FAIL wrap_four: got %h want 04", out_pc); end
    tick();
    out_ready = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL wrap_left: got %0d left want 0", exp_q.size()); end
  endtask

  task automatic test_reset_mid;
    tick();
    total++; if (out_valid !== 1'b1 || out_pc !== 8'h08 || imem_addr !== 8'h10)
      begin bad++; $display("FAIL mid_prefill: got %b/%h/%h want 1/08/10", out_valid, out_pc, imem_addr); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    exp_q.push_back({8'h00, 32'h00007033});
    total++; if (out_valid !== 1'b0 || out_pc !== 8'h00 || out_instr !== 32'h0)
      begin bad++; $display("FAIL mid_cleared: got %b/%h/%h want 0/00/0", out_valid, out_pc, out_instr); end
    total++; if (imem_addr !== 8'h00) begin bad++; $display("FAIL mid_addr: got %h want 00", imem_addr); end
    tick();
    total++; if (out_valid !== 1'b1 || out_instr !== 32'h00007033)
      begin bad++; $display("FAIL mid_restart: got %b/%h want 1/00007033", out_valid, out_instr); end
    tick();
    out_ready = 1'b0;
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL mid_left: got %0d left want 0", exp_q.size()); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid();
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
